// File: rtl/debounce_multi.sv
// Multi-channel pushbutton debouncer: synchroniser, stability filter, press/release
// strobes, clean level and optional per-channel auto-repeat.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | released and stable; waiting for the synchronised input to rise
// ARMING    | input high; scnt counts down the stability window before a press
// PRESSED   | press accepted; rcnt times the next auto-repeat pulse
// RELEASING | input low; scnt counts down the stability window before a release
module debounce_multi #(
  parameter int              N_CH          = 5,
  parameter int              SYNC_STAGES   = 2,
  parameter int              STABLE_CYCLES = 1000000,
  parameter int              REPEAT_DELAY  = 25000000,
  parameter int              REPEAT_PERIOD = 5000000,
  parameter logic [N_CH-1:0] REPEAT_EN     = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] level
);

  localparam int MAX_SR  = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_SR > REPEAT_PERIOD) ? MAX_SR : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  s;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [CW-1:0]   scnt_q  [N_CH];
  logic [CW-1:0]   scnt_d  [N_CH];
  logic [CW-1:0]   rcnt_q  [N_CH];
  logic [CW-1:0]   rcnt_d  [N_CH];
  logic [N_CH-1:0] pulse_q, pulse_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic [N_CH-1:0] level_q, level_d;

  // Only the last synchroniser stage is allowed to reach the channel FSMs.
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      scnt_d[i]  = scnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      pulse_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      level_d[i] = level_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = ARMING;
            scnt_d[i]  = STABLE_LOAD;
          end
        end
        ARMING: begin
          if (!s[i]) begin
            state_d[i] = IDLE;
          end else if (scnt_q[i] == '0) begin
            state_d[i] = PRESSED;
            pulse_d[i] = 1'b1;
            level_d[i] = 1'b1;
            rcnt_d[i]  = DELAY_LOAD;
          end else begin
            scnt_d[i] = scnt_q[i] - CNT_ONE;
          end
        end
        PRESSED: begin
          // rcnt is left alone on the way out so an absorbed release bounce
          // does not restart or advance the repeat timing.
          if (!s[i]) begin
            state_d[i] = RELEASING;
            scnt_d[i]  = STABLE_LOAD;
          end else if (REPEAT_EN[i] && (rcnt_q[i] == '0)) begin
            pulse_d[i] = 1'b1;
            rcnt_d[i]  = PERIOD_LOAD;
          end else if (rcnt_q[i] != '0) begin
            rcnt_d[i] = rcnt_q[i] - CNT_ONE;
          end
        end
        RELEASING: begin
          if (s[i]) begin
            state_d[i] = PRESSED;
          end else if (scnt_q[i] == '0) begin
            state_d[i] = IDLE;
            rel_d[i]   = 1'b1;
            level_d[i] = 1'b0;
          end else begin
            scnt_d[i] = scnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        scnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
      end
      pulse_q <= '0;
      rel_q   <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        scnt_q[i]  <= scnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      level_q <= level_d;
    end
  end

  assign pulse         = pulse_q;
  assign release_pulse = rel_q;
  assign level         = level_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random button activity, all
// compared cycle by cycle against a run-length based reference model.
module tb_debounce_multi;

  localparam int        NC  = 2;
  localparam int        SS  = 2;
  localparam int        SC  = 4;
  localparam int        RD  = 10;
  localparam int        RP  = 3;
  localparam logic [1:0] REN = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] btn = '0;
  logic [NC-1:0] pulse, release_pulse, level;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [NC-1:0] bh [SS];
  int            run_m  [NC];
  int            held_m [NC];
  logic [NC-1:0] lvl_m, pul_m, rel_m;

  debounce_multi #(
    .N_CH(NC), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(REN)
  ) dut (
    .clk(clk), .reset(rst), .button(btn),
    .pulse(pulse), .release_pulse(release_pulse), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A value is accepted once the synchronised input has differed from the
  // accepted level for SC+1 consecutive samples. Repeats count held samples.
  task automatic model_edge(input logic [NC-1:0] b, input logic r);
    logic [NC-1:0] sv;
    pul_m = '0;
    rel_m = '0;
    if (r) begin
      for (int k = 0; k < SS; k++) bh[k] = '0;
      for (int i = 0; i < NC; i++) begin
        run_m[i]  = 0;
        held_m[i] = 0;
      end
      lvl_m = '0;
      return;
    end
    sv = bh[SS-1];
    for (int i = 0; i < NC; i++) begin
      if (sv[i] != lvl_m[i]) begin
        run_m[i]++;
        if (run_m[i] == SC + 1) begin
          lvl_m[i] = sv[i];
          run_m[i] = 0;
          if (sv[i]) begin
            pul_m[i]  = 1'b1;
            held_m[i] = 0;
          end else begin
            rel_m[i] = 1'b1;
          end
        end
      end else begin
        if (lvl_m[i] && run_m[i] == 0) begin
          held_m[i]++;
          if (REN[i] && held_m[i] >= RD && ((held_m[i] - RD) % RP) == 0) pul_m[i] = 1'b1;
        end
        run_m[i] = 0;
      end
    end
    for (int k = SS - 1; k > 0; k--) bh[k] = bh[k-1];
    bh[0] = b;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(btn, rst);
    #1;
    chk("pulse", 32'(pulse), 32'(pul_m));
    chk("release_pulse", 32'(release_pulse), 32'(rel_m));
    chk("level", 32'(level), 32'(lvl_m));
  endtask

  int first, npul, nrel;
  int pul_times [$];

  initial begin
    for (int k = 0; k < SS; k++) bh[k] = '0;
    lvl_m = '0; pul_m = '0; rel_m = '0;
    for (int i = 0; i < NC; i++) begin run_m[i] = 0; held_m[i] = 0; end

    rst = 1'b1; btn = '0;
    step(); step();
    chk("reset_outputs", 32'({pulse, release_pulse, level}), 32'd0);
    rst = 1'b0;
    step(); step();

    // clean press on ch0, held 40 cycles, clean release
    btn = 2'b01;
    step();
    first = -1; npul = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (pulse[0]) begin npul++; if (first < 0) first = k; end
    end
    chk("press_latency", 32'(first), 32'd6);
    chk("press_pulse_count", 32'(npul), 32'd1);
    chk("press_level", 32'(level[0]), 32'd1);
    btn = 2'b00;
    step();
    first = -1; nrel = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (release_pulse[0]) begin nrel++; if (first < 0) first = k; end
    end
    chk("release_latency", 32'(first), 32'd6);
    chk("release_count", 32'(nrel), 32'd1);
    chk("release_level", 32'(level[0]), 32'd0);

    // 3-cycle glitch is rejected
    btn = 2'b01;
    step(); step(); step();
    btn = 2'b00;
    npul = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (pulse[0] || release_pulse[0] || level[0]) npul++;
    end
    chk("glitch_no_activity", 32'(npul), 32'd0);

    // release bounce absorbed
    btn = 2'b01;
    for (int k = 0; k < 12; k++) step();
    btn = 2'b00;
    step(); step();
    btn = 2'b01;
    npul = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (pulse[0] || release_pulse[0] || !level[0]) npul++;
    end
    chk("bounce_absorbed", 32'(npul), 32'd0);
    btn = 2'b00;
    for (int k = 0; k < 10; k++) step();

    // auto-repeat on ch1, held 30 cycles past the press pulse
    btn = 2'b10;
    step();
    first = -1;
    pul_times.delete();
    for (int k = 1; k <= 36; k++) begin
      step();
      if (pulse[1]) begin
        if (first < 0) first = k;
        pul_times.push_back(k - first);
      end
    end
    chk("repeat_count", 32'(pul_times.size()), 32'd8);
    if (pul_times.size() == 8) begin
      chk("repeat_first", 32'(pul_times[1]), 32'd10);
      chk("repeat_last", 32'(pul_times[7]), 32'd28);
    end
    btn = 2'b00;
    nrel = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (release_pulse[1]) nrel++;
    end
    chk("repeat_release_count", 32'(nrel), 32'd1);

    // simultaneous press
    btn = 2'b11;
    step();
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (pulse != 2'b00 && first < 0) begin
        first = k;
        chk("simultaneous_pulse", 32'(pulse), 32'd3);
      end
    end
    chk("simultaneous_latency", 32'(first), 32'd6);
    btn = 2'b00;
    for (int k = 0; k < 10; k++) step();

    // reset while ch0 is pressed and still held
    btn = 2'b01;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    chk("midreset_outputs", 32'({pulse, release_pulse, level}), 32'd0);
    rst = 1'b0;
    first = -1; nrel = 0;
    for (int k = 0; k <= 12; k++) begin
      step();
      if (pulse[0] && first < 0) first = k;
      if (release_pulse[0]) nrel++;
    end
    chk("midreset_repress", 32'(first), 32'd6);
    chk("midreset_no_release", 32'(nrel), 32'd0);
    btn = 2'b00;
    for (int k = 0; k < 10; k++) step();

    // random activity: fast bouncing, then slow holds that reach auto-repeat
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button pulse debouncer.
- Each channel does the following:
  - synchronises a raw pushbutton input;
  - requires the input to stay stable for a set time before accepting a press or release;
  - emits one-cycle press and release pulses and a clean debounced level;
  - optionally emits auto-repeat pulses while the button is held.
- Sits between the board buttons and the processor's step/control logic, for example single-step clock enable and display-mode select.

Parameters:
- N_CH, 5: number of independent button channels.
- SYNC_STAGES, 2: synchroniser flop depth, minimum 2.
- STABLE_CYCLES, 1000000: cycles the input must hold a new value before it is accepted, minimum 1.
- REPEAT_DELAY, 25000000: cycles from the accepted press to the first repeat pulse, minimum 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses, minimum 1.
- REPEAT_EN, {N_CH{1'b0}}: per-channel auto-repeat enable mask; bit i applies to channel i.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- button  input  N_CH  raw asynchronous button levels.
- pulse  output  N_CH  one-cycle strobe on an accepted press and on each repeat.
- release_pulse  output  N_CH  one-cycle strobe on an accepted release.
- level  output  N_CH  debounced button level.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset. All flops update only on posedge clk.
- Reset values:
  - sync chains, counters, pulse, release_pulse and level are all 0;
  - every channel FSM is in IDLE.
- Channel independence: channels share no state. Any combination of channels may transition in the same cycle.
- Synchroniser: button[i] passes through SYNC_STAGES flops. The last stage (s[i]) is the only value the FSM sees.
- Counter width: each channel has a stability counter scnt and a repeat counter rcnt. Both are $clog2(max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1) bits wide and must never wrap below 0.
- FSM states and transitions, per channel. State, counters and all outputs are registered.
  - IDLE:
    - s=1: go to ARMING, scnt <= STABLE_CYCLES-1.
    - Otherwise stay in IDLE.
  - ARMING:
    - s=0: go to IDLE, with no pulse.
    - Else if scnt==0: go to PRESSED, pulse<=1, level<=1, rcnt <= REPEAT_DELAY-1.
    - Otherwise scnt decrements.
  - PRESSED:
    - s=0: go to RELEASING, scnt <= STABLE_CYCLES-1, rcnt holds.
    - Else if REPEAT_EN[i] and rcnt==0: pulse<=1, rcnt <= REPEAT_PERIOD-1.
    - Else if rcnt!=0: rcnt decrements.
  - RELEASING:
    - s=1: return to PRESSED, with no pulse and rcnt unchanged (the bounce is absorbed).
    - Else if scnt==0: go to IDLE, release_pulse<=1, level<=0.
    - Otherwise scnt decrements.
- Pulse width: pulse and release_pulse are 1 for exactly one cycle per event and are cleared on the next edge.
- Press latency: count the edge that first samples button=1 into the first sync stage as edge 0. pulse is high in the cycle following edge SYNC_STAGES+STABLE_CYCLES, provided the input is held high throughout.
- Release latency: symmetric to press latency, with release_pulse and level falling instead.
- Glitch rejection: a glitch shorter than STABLE_CYCLES (after synchronisation) in either direction produces no pulse and no level change.
- Auto-repeat: the first repeat pulse comes REPEAT_DELAY cycles after the press pulse. Subsequent repeats come every REPEAT_PERIOD cycles. Time spent in RELEASING does not advance rcnt.
- REPEAT_EN[i]=0: exactly one pulse per press, regardless of hold duration.
- Reset mid-operation: all state clears on the reset edge. If the button is still held after reset deasserts, the channel re-arms and issues a fresh press pulse after the full latency. No release_pulse is issued for the aborted press.

Test Plan:
Parameters for all tests: N_CH=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=2'b10.
- Clean press on ch0, held 40 cycles then released cleanly -> the following must all hold:
  - pulse[0] high for 1 cycle after edge 6;
  - level[0]=1 from that point;
  - no further pulse[0];
  - release_pulse[0] for 1 cycle 6 edges after button falls, with level[0]=0.
- Glitch rejection: button[0] high for 3 cycles, then low -> pulse[0], level[0] and release_pulse[0] stay 0 throughout.
- Release bounce: ch0 held, then low for 2 cycles, then high again -> level[0] stays 1, with no release_pulse and no extra pulse.
- Auto-repeat on ch1, held 30 cycles after the press pulse -> pulse[1] at press, +10, +13, +16, +19, +22, +25, +28 cycles; one release_pulse[1] after release.
- Simultaneous activity: both channels pressed in the same cycle -> pulse[0] and pulse[1] assert in the same cycle, independently.
- Reset asserted while ch0 is in PRESSED with button still held -> all outputs are 0 the cycle after the reset edge; after deassert, a new pulse[0] comes 6 edges later; no release_pulse.
